spbram_queue_initiator: RTL and testbench

//  Circular FIFO queue built on one single-port BRAM region, accessed through the BRAM

---
 rtl/spbram_queue_initiator_pkg.sv | 16 +
 rtl/spbram_queue_initiator.sv | 128 ++++++++++++
 tb/tb_spbram_queue_initiator.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spbram_queue_initiator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spbram_queue_initiator_pkg : read-FSM encodings and slot-stride default  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package spbram_queue_initiator_pkg;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_t;

  localparam int unsigned c_DEFAULT_ADDR_STRIDE = 4;

endpackage
`default_nettype wire

// File: rtl/spbram_queue_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spbram_queue_initiator : circular FIFO over one BRAM region, driving the |
// | write/read request channels of the dual-port control block. Rev 1.0      |
// +--------------------------------------------------------------------------+
module spbram_queue_initiator
  import spbram_queue_initiator_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0,
  parameter int          DEPTH_LOG2  = 4,
  parameter int unsigned ADDR_STRIDE = c_DEFAULT_ADDR_STRIDE
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic [31:0]           iPushData,
  input  logic                  iPushValid,
  output logic                  oPushReady,
  output logic [31:0]           oPopData,
  output logic                  oPopValid,
  input  logic                  iPopReady,
  output logic [31:0]           oWriteAddress,
  output logic [31:0]           oWriteData,
  output logic                  oWriteValid,
  input  logic                  iWriteAck,
  output logic [31:0]           oReadAddress,
  output logic                  oReadValid,
  input  logic                  iReadAck,
  input  logic [31:0]           iReadData,
  output logic [DEPTH_LOG2:0]   oLevel,
  output logic                  oFull,
  output logic                  oEmpty
);

  localparam logic [DEPTH_LOG2:0]   c_LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   c_LEVEL_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE    = 1;

  function automatic logic [31:0] slot_addr(input logic [DEPTH_LOG2-1:0] ptr);
    return ADDR_BASE + (32'(ptr) * 32'(ADDR_STRIDE));
  endfunction

  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [31:0]           r_read_addr;
  logic                  r_read_valid;
  logic [31:0]           r_pop_data;
  logic                  r_pop_valid;
  rd_state_t             r_state;
  rd_state_t             w_state_next;
  logic                  w_latch_rptr;
  logic                  w_full;
  logic                  w_push_fire;
  logic                  w_read_fire;

  // Write channel is purely combinational: the control block acks in-cycle.
  assign w_full        = (r_level == c_LEVEL_FULL);
  assign oWriteValid   = iPushValid && !w_full;
  assign oPushReady    = !w_full && iWriteAck;
  assign oWriteData    = iPushData;
  assign oWriteAddress = slot_addr(r_wptr);
  assign w_push_fire   = iPushValid && oPushReady;
  assign w_read_fire   = r_read_valid && iReadAck;

  always_comb begin
    w_state_next = r_state;
    w_latch_rptr = 1'b0;
    case (r_state)
      RD_IDLE: begin
        // Only fetch when the pop register is free, so the fetched word always has a home.
        if ((r_level != '0) && !r_pop_valid) begin
          w_state_next = RD_WAIT;
          w_latch_rptr = 1'b1;
        end
      end
      RD_WAIT: begin
        if (w_read_fire) begin
          w_state_next = RD_IDLE;
        end
      end
      default: w_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state      <= RD_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_read_addr  <= '0;
      r_read_valid <= 1'b0;
      r_pop_data   <= '0;
      r_pop_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_read_valid <= (w_state_next == RD_WAIT);
      if (w_latch_rptr) begin
        r_read_addr <= slot_addr(r_rptr);
      end
      if (w_push_fire) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_read_fire) begin
        r_rptr      <= r_rptr + c_PTR_ONE;
        r_pop_data  <= iReadData;
        r_pop_valid <= 1'b1;
      end else if (r_pop_valid && iPopReady) begin
        r_pop_valid <= 1'b0;
      end
      case ({w_push_fire, w_read_fire})
        2'b10:   r_level <= r_level + c_LEVEL_ONE;
        2'b01:   r_level <= r_level - c_LEVEL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  assign oReadAddress = r_read_addr;
  assign oReadValid   = r_read_valid;
  assign oPopData     = r_pop_data;
  assign oPopValid    = r_pop_valid;
  assign oLevel       = r_level;
  assign oFull        = w_full;
  assign oEmpty       = (r_level == '0) && !r_pop_valid;

endmodule
`default_nettype wire

// File: tb/tb_spbram_queue_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spbram_queue_initiator : two queue instances (16 and 4 slots), each   |
// | with a write-first control block model over a BRAM array. Rev 1.0       |
// +--------------------------------------------------------------------------+
module tb_spbram_queue_initiator;

  localparam logic [31:0] c_BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic log_clr;
  logic push_valid;
  logic pop_ready;
  logic [31:0] push_data;

  always #5 clk = ~clk;

  // Instance A: DEPTH_LOG2 = 4
  logic        a_push_ready, a_pop_valid, a_wv, a_wack, a_rv, a_rack, a_full, a_empty;
  logic [31:0] a_pop_data, a_wa, a_wd, a_ra, a_rd;
  logic [4:0]  a_level;
  logic [31:0] a_mem [16];
  logic [3:0]  a_widx, a_ridx;

  // Instance B: DEPTH_LOG2 = 2
  logic        b_push_ready, b_pop_valid, b_wv, b_wack, b_rv, b_rack, b_full, b_empty;
  logic [31:0] b_pop_data, b_wa, b_wd, b_ra, b_rd;
  logic [2:0]  b_level;
  logic [31:0] b_mem [4];
  logic [1:0]  b_widx, b_ridx;

  spbram_queue_initiator #(.ADDR_BASE(c_BASE), .DEPTH_LOG2(4), .ADDR_STRIDE(4)) u_dut_a (
    .iClock(clk), .iReset(rst),
    .iPushData(push_data), .iPushValid(push_valid), .oPushReady(a_push_ready),
    .oPopData(a_pop_data), .oPopValid(a_pop_valid), .iPopReady(pop_ready),
    .oWriteAddress(a_wa), .oWriteData(a_wd), .oWriteValid(a_wv), .iWriteAck(a_wack),
    .oReadAddress(a_ra), .oReadValid(a_rv), .iReadAck(a_rack), .iReadData(a_rd),
    .oLevel(a_level), .oFull(a_full), .oEmpty(a_empty)
  );

  spbram_queue_initiator #(.ADDR_BASE(c_BASE), .DEPTH_LOG2(2), .ADDR_STRIDE(4)) u_dut_b (
    .iClock(clk), .iReset(rst),
    .iPushData(push_data), .iPushValid(push_valid), .oPushReady(b_push_ready),
    .oPopData(b_pop_data), .oPopValid(b_pop_valid), .iPopReady(pop_ready),
    .oWriteAddress(b_wa), .oWriteData(b_wd), .oWriteValid(b_wv), .iWriteAck(b_wack),
    .oReadAddress(b_ra), .oReadValid(b_rv), .iReadAck(b_rack), .iReadData(b_rd),
    .oLevel(b_level), .oFull(b_full), .oEmpty(b_empty)
  );

  // Control block models: writes acked in-cycle and served first; reads acked only
  // in a cycle with no write, returning the array contents for that address.
  assign a_wack = a_wv;
  assign a_rack = a_rv && !a_wv;
  assign a_widx = 4'((a_wa - c_BASE) >> 2);
  assign a_ridx = 4'((a_ra - c_BASE) >> 2);
  assign a_rd   = a_mem[a_ridx];
  always @(posedge clk) if (a_wv && a_wack) a_mem[a_widx] <= a_wd;

  assign b_wack = b_wv;
  assign b_rack = b_rv && !b_wv;
  assign b_widx = 2'((b_wa - c_BASE) >> 2);
  assign b_ridx = 2'((b_ra - c_BASE) >> 2);
  assign b_rd   = b_mem[b_ridx];
  always @(posedge clk) if (b_wv && b_wack) b_mem[b_widx] <= b_wd;

  logic        o_push_ready, o_pop_valid, o_rv, o_full, o_empty, o_wfire, o_rfire;
  logic [31:0] o_pop_data, o_wa, o_ra;
  logic [4:0]  o_level;

  always_comb begin
    if (sel) begin
      o_push_ready = b_push_ready; o_pop_valid = b_pop_valid; o_pop_data = b_pop_data;
      o_rv = b_rv; o_ra = b_ra; o_wa = b_wa; o_full = b_full; o_empty = b_empty;
      o_level = {2'b00, b_level}; o_wfire = b_wv && b_wack; o_rfire = b_rv && b_rack;
    end else begin
      o_push_ready = a_push_ready; o_pop_valid = a_pop_valid; o_pop_data = a_pop_data;
      o_rv = a_rv; o_ra = a_ra; o_wa = a_wa; o_full = a_full; o_empty = a_empty;
      o_level = a_level; o_wfire = a_wv && a_wack; o_rfire = a_rv && a_rack;
    end
  end

  logic [31:0] wq[$];
  logic [31:0] rq[$];
  logic [31:0] pq[$];

  always @(posedge clk) begin
    if (log_clr) begin
      wq.delete(); rq.delete(); pq.delete();
    end else if (!rst) begin
      if (o_wfire) wq.push_back(o_wa);
      if (o_rfire) rq.push_back(o_ra);
      if (o_pop_valid && pop_ready) pq.push_back(o_pop_data);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input logic s);
    sel = s; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
    rst = 1'b1; log_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; log_clr = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    bit done = 0;
    push_valid = 1'b1; push_data = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (o_push_ready) done = 1;
      @(posedge clk); #1;
    end
    push_valid = 1'b0;
    check("push_accept", 32'(done), 32'd1);
  endtask

  task automatic pop_word(input logic [31:0] exp);
    bit got = 0;
    pop_ready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (o_pop_valid) begin
        got = 1;
        check("pop_data", o_pop_data, exp);
      end
      @(posedge clk); #1;
    end
    pop_ready = 1'b0;
    check("pop_arrives", 32'(got), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        pv;
    logic [31:0] pd;
    logic        pr;
    logic        e_push_ready;
    logic [31:0] e_wa;
    logic        e_pop_valid;
    logic [31:0] e_pop_data;
    logic        e_rv;
    logic [31:0] e_ra;
    logic [4:0]  e_level;
    logic        e_empty;
  } vec_t;

  vec_t vecs [12];

  initial begin : main
    // Three back-to-back pushes; the third write stalls the first read by one cycle.
    vecs[0]  = '{1'b1, 32'hA0, 1'b1, 1'b1, c_BASE + 32'd0, 1'b0, 32'h0,  1'b0, 32'h0,           5'd0, 1'b1};
    vecs[1]  = '{1'b1, 32'hA1, 1'b1, 1'b1, c_BASE + 32'd4, 1'b0, 32'h0,  1'b0, 32'h0,           5'd1, 1'b0};
    vecs[2]  = '{1'b1, 32'hA2, 1'b1, 1'b1, c_BASE + 32'd8, 1'b0, 32'h0,  1'b1, c_BASE + 32'd0, 5'd2, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,          1'b0, 32'h0,  1'b1, c_BASE + 32'd0, 5'd3, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,          1'b1, 32'hA0, 1'b0, 32'h0,           5'd2, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,          1'b0, 32'h0,  1'b0, 32'h0,           5'd2, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,          1'b0, 32'h0,  1'b1, c_BASE + 32'd4, 5'd2, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,          1'b1, 32'hA1, 1'b0, 32'h0,           5'd1, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,          1'b0, 32'h0,  1'b0, 32'h0,           5'd1, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,          1'b0, 32'h0,  1'b1, c_BASE + 32'd8, 5'd1, 1'b0};
    vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,          1'b1, 32'hA2, 1'b0, 32'h0,           5'd0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,          1'b0, 32'h0,  1'b0, 32'h0,           5'd0, 1'b1};

    // ---- 1: reset values, then table-driven push/pop of A0..A2
    do_reset(1'b0);
    @(negedge clk);
    check("rst pop_valid", 32'(o_pop_valid), 32'd0);
    check("rst pop_data",  o_pop_data, 32'd0);
    check("rst read_valid", 32'(o_rv), 32'd0);
    check("rst level", 32'(o_level), 32'd0);
    check("rst empty", 32'(o_empty), 32'd1);
    check("rst full", 32'(o_full), 32'd0);
    tick();
    for (int k = 0; k < 12; k++) begin
      push_valid = vecs[k].pv; push_data = vecs[k].pd; pop_ready = vecs[k].pr;
      @(negedge clk);
      check($sformatf("t1[%0d] push_ready", k), 32'(o_push_ready), 32'(vecs[k].e_push_ready));
      if (vecs[k].pv) check($sformatf("t1[%0d] write_addr", k), o_wa, vecs[k].e_wa);
      check($sformatf("t1[%0d] pop_valid", k), 32'(o_pop_valid), 32'(vecs[k].e_pop_valid));
      if (vecs[k].e_pop_valid) check($sformatf("t1[%0d] pop_data", k), o_pop_data, vecs[k].e_pop_data);
      check($sformatf("t1[%0d] read_valid", k), 32'(o_rv), 32'(vecs[k].e_rv));
      if (vecs[k].e_rv) check($sformatf("t1[%0d] read_addr", k), o_ra, vecs[k].e_ra);
      check($sformatf("t1[%0d] level", k), 32'(o_level), 32'(vecs[k].e_level));
      check($sformatf("t1[%0d] empty", k), 32'(o_empty), 32'(vecs[k].e_empty));
      tick();
    end

    // ---- 2: 4-slot queue fills to DEPTH+1, sixth push waits for a pop
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) push_word(32'hD0 + 32'(i));
    repeat (6) tick();
    @(negedge clk);
    check("t2 pop_valid", 32'(o_pop_valid), 32'd1);
    check("t2 pop_data", o_pop_data, 32'hD0);
    check("t2 level", 32'(o_level), 32'd4);
    check("t2 full", 32'(o_full), 32'd1);
    tick();
    push_valid = 1'b1; push_data = 32'hD5;
    @(negedge clk);
    check("t2 push_ready when full", 32'(o_push_ready), 32'd0);
    tick();
    pop_word(32'hD0);
    push_word(32'hD5);
    for (int i = 1; i < 6; i++) pop_word(32'hD0 + 32'(i));
    @(negedge clk);
    check("t2 drained level", 32'(o_level), 32'd0);
    check("t2 drained empty", 32'(o_empty), 32'd1);
    tick();

    // ---- 3: stream 10 words through the 4-slot queue across pointer wrap
    do_reset(1'b1);
    pop_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(32'hC0 + 32'(i));
    pop_ready = 1'b1;
    for (int i = 0; i < 200 && pq.size() < 10; i++) tick();
    pop_ready = 1'b0;
    check("t3 pop count", 32'(pq.size()), 32'd10);
    check("t3 write count", 32'(wq.size()), 32'd10);
    check("t3 read count", 32'(rq.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < wq.size()) check($sformatf("t3 write_addr[%0d]", i), wq[i], c_BASE + 32'(4 * (i % 4)));
      if (i < rq.size()) check($sformatf("t3 read_addr[%0d]", i), rq[i], c_BASE + 32'(4 * (i % 4)));
      if (i < pq.size()) check($sformatf("t3 pop_data[%0d]", i), pq[i], 32'hC0 + 32'(i));
    end

    // ---- 4: continuous pushes starve RD_WAIT; request held until a free cycle
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      push_valid = 1'b1; push_data = 32'hE0 + 32'(i);
      @(negedge clk);
      check($sformatf("t4[%0d] push_ready", i), 32'(o_push_ready), 32'd1);
      if (i >= 2) begin
        check($sformatf("t4[%0d] read_valid", i), 32'(o_rv), 32'd1);
        check($sformatf("t4[%0d] read_addr", i), o_ra, c_BASE);
      end
      tick();
    end
    push_valid = 1'b0;
    @(negedge clk);
    check("t4 read_valid in free cycle", 32'(o_rv), 32'd1);
    tick();
    @(negedge clk);
    check("t4 pop_valid", 32'(o_pop_valid), 32'd1);
    check("t4 pop_data", o_pop_data, 32'hE0);
    tick();
    for (int i = 0; i < 8; i++) pop_word(32'hE0 + 32'(i));

    // ---- 5: reset while a read is outstanding
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_data = 32'hF0 + 32'(i);
      @(negedge clk);
      if (i == 2) check("t5 read_valid before reset", 32'(o_rv), 32'd1);
      tick();
    end
    push_valid = 1'b0; rst = 1'b1; log_clr = 1'b1;
    tick();
    rst = 1'b0; log_clr = 1'b0;
    @(negedge clk);
    check("t5 read_valid after reset", 32'(o_rv), 32'd0);
    check("t5 pop_valid after reset", 32'(o_pop_valid), 32'd0);
    check("t5 level after reset", 32'(o_level), 32'd0);
    check("t5 empty after reset", 32'(o_empty), 32'd1);
    tick();
    push_word(32'h55);
    pop_word(32'h55);
    check("t5 read count", 32'(rq.size()), 32'd1);
    if (rq.size() > 0) check("t5 read_addr", rq[0], c_BASE);
    if (wq.size() > 0) check("t5 write_addr", wq[0], c_BASE);

    // ---- 6: latency t+3 from an idle queue, then a held pop register
    do_reset(1'b0);
    push_valid = 1'b1; push_data = 32'h66;
    tick();
    push_valid = 1'b0;
    @(negedge clk);
    check("t6 pop_valid t+1", 32'(o_pop_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t6 pop_valid t+2", 32'(o_pop_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t6 pop_valid t+3", 32'(o_pop_valid), 32'd1);
    check("t6 pop_data t+3", o_pop_data, 32'h66);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("t6 hold[%0d] pop_valid", i), 32'(o_pop_valid), 32'd1);
      check($sformatf("t6 hold[%0d] pop_data", i), o_pop_data, 32'h66);
    end
    tick();
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("t6 pop count", 32'(pq.size()), 32'd1);
    check("t6 pop_valid after pop", 32'(o_pop_valid), 32'd0);
    check("t6 empty after pop", 32'(o_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
